i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
- REQ-001 Parameter CLK_DIV, default 4: CLK cycles per SCL quarter-period; legal range 1..255.
- REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
- REQ-003 Reset  input  1  asynchronous, active-low reset.
- REQ-004 Start  input  1  transaction request; sampled only while Busy=0.
- REQ-005 RW  input  1  0=write one byte, 1=read one byte.
- REQ-006 Addr  input  7  7-bit slave address.
- REQ-007 WrData  input  8  byte to write.
- REQ-008 SCL  output  1  I2C clock driven to the slave.
- REQ-009 oSDA  output  1  SDA driven to the slave; 1=released/high.
- REQ-010 iSDA  input  1  SDA level returned by the slave (ACK, read data).
- REQ-011 RdData  output  8  byte read; valid from the Done pulse until the next accepted Start.
- REQ-012 Busy  output  1  high from the cycle after Start is accepted until Done.
- REQ-013 Done  output  1  one-cycle pulse at end of transaction.
- REQ-014 AckErr  output  1  NACK seen in the last transaction; valid with Done, held until the next accepted Start.

Function
- REQ-015 States SHALL be IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RNACK, STOP.
- REQ-016 Each non-IDLE state SHALL be built from bit slots of 4 quarters (q0..q3), each quarter CLK_DIV cycles long; a bit slot is therefore 4*CLK_DIV cycles.
- REQ-017 Data slots: SCL=0 in q0,q1 and SCL=1 in q2,q3; oSDA updated only at q0 entry; iSDA sampled on the last cycle of q2.
- REQ-018 START (1 slot): SCL=1 throughout; oSDA=1 in q0,q1 and oSDA=0 in q2,q3.
- REQ-019 ADDR (8 slots): shift out {Addr, RW} MSB first.
- REQ-020 ADDR_ACK (1 slot): oSDA=1; iSDA=0 -> WDATA (RW=0) or RDATA (RW=1); iSDA=1 -> AckErr=1, go to STOP.
- REQ-021 WDATA (8 slots): shift out WrData MSB first; then WDATA_ACK (1 slot, oSDA=1); iSDA=1 there sets AckErr=1; then STOP.
- REQ-022 RDATA (8 slots): oSDA=1; shift sampled iSDA into RdData MSB first; then RNACK (1 slot, oSDA=1 = master NACK); then STOP.
- REQ-023 STOP (1 slot): q0,q1 SCL=0 oSDA=0; q2 SCL=1 oSDA=0; q3 SCL=1 oSDA=1; then IDLE.
- REQ-024 Done SHALL pulse in the first IDLE cycle after STOP; Busy drops in that same cycle.
- REQ-025 Latency: Start accepted at cycle N -> Done at N+1+80*CLK_DIV for a full transaction, N+1+44*CLK_DIV for an address NACK.
- REQ-026 On the accepting edge, RW, Addr and WrData SHALL be captured; later input changes have no effect on the transaction.
- REQ-027 On the accepting edge, AckErr SHALL be cleared and RdData SHALL be cleared to 0.
- REQ-028 Start while Busy=1 SHALL be ignored, with no queuing.
- REQ-029 Start held high through Done SHALL begin a new transaction on the cycle after Done.
- REQ-030 In IDLE, SCL=1 and oSDA=1.
- REQ-031 A quarter counter SHALL count 0..CLK_DIV-1 and wrap; a bit counter SHALL count 7..0 for the shift states.

Reset
- REQ-032 Reset=0 SHALL immediately force, regardless of CLK: state IDLE, SCL=1, oSDA=1, Busy=0, Done=0, AckErr=0, RdData=8'h00, all counters 0.
- REQ-033 Reset asserted mid-transaction SHALL abort it with no STOP and no Done.
- REQ-034 After Reset releases, the block SHALL be in IDLE and accept Start on the first rising CLK edge.

Verification
- REQ-035 Write: CLK_DIV=4, Addr=7'h2A, RW=0, WrData=8'hA5, slave ACKs both -> SDA bits 0x54 then 0xA5 on the SCL rising edges; Done 321 cycles after Start; AckErr=0.
- REQ-036 Read: Addr=7'h2A, RW=1, slave drives 8'h3C -> RdData=8'h3C at Done; master oSDA=1 in RNACK slot; AckErr=0.
- REQ-037 Address NACK: iSDA held 1 -> AckErr=1; STOP follows ADDR_ACK directly; Done 177 cycles after Start.
- REQ-038 Busy collision: second Start pulse mid-ADDR with different Addr -> ignored; exactly one Done; SDA shows the first address only.
- REQ-039 Reset mid-WDATA: Reset=0 for 3 cycles -> SCL=1 and oSDA=1 asynchronously, Busy=0, no Done; a following write completes normally.
- REQ-040 Protocol checker across all scenarios: SDA changes only while SCL=0, except the START falling edge and the STOP rising edge.

Source files
------------

// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
//   Single-byte I2C master. One request moves a START, the 7-bit address plus
//   R/W bit, the address ACK, one data byte (written or read), the data ACK
//   (slave ACK on write, master NACK on read) and a STOP. Every bus bit is a
//   slot of four quarters, each CLK_DIV system clocks long.
//
// Parameters
//   CLK_DIV  system clocks per SCL quarter period (1..255)
//
// Ports
//   CLK     in   system clock, rising edge
//   Reset   in   asynchronous active-low reset
//   Start   in   transaction request, honoured only while Busy=0
//   RW      in   0 = write one byte, 1 = read one byte
//   Addr    in   7-bit slave address
//   WrData  in   byte to write
//   SCL     out  I2C clock towards the slave
//   oSDA    out  SDA towards the slave, 1 = released/high
//   iSDA    in   SDA level returned by the slave (ACK, read data)
//   RdData  out  byte read, valid from Done until the next accepted Start
//   Busy    out  high from the cycle after acceptance until Done
//   Done    out  one-cycle pulse at the end of a transaction
//   AckErr  out  a NACK was seen in the last transaction
// ---------------------------------------------------------------------------
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  input  logic       RW,
  input  logic [6:0] Addr,
  input  logic [7:0] WrData,
  output logic       SCL,
  output logic       oSDA,
  input  logic       iSDA,
  output logic [7:0] RdData,
  output logic       Busy,
  output logic       Done,
  output logic       AckErr
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] START     = 4'd1;
  localparam logic [3:0] ADDR      = 4'd2;
  localparam logic [3:0] ADDR_ACK  = 4'd3;
  localparam logic [3:0] WDATA     = 4'd4;
  localparam logic [3:0] WDATA_ACK = 4'd5;
  localparam logic [3:0] RDATA     = 4'd6;
  localparam logic [3:0] RNACK     = 4'd7;
  localparam logic [3:0] STOP      = 4'd8;

  localparam logic [7:0] QUARTER_LAST = 8'(CLK_DIV - 1);

  logic [3:0] state;
  logic [3:0] nextState;
  logic [7:0] quarterCnt;
  logic [7:0] nextQuarterCnt;
  logic [1:0] quarter;
  logic [1:0] nextQuarter;
  logic [2:0] bitCnt;
  logic [2:0] nextBitCnt;
  logic [7:0] addrByte;
  logic [7:0] wrByte;
  logic [1:0] busNext;
  logic       accept;
  logic       quarterEnd;
  logic       slotEnd;
  logic       sampleNow;

  // Bus levels {SCL, SDA} for a given position inside a transaction. SCL and
  // oSDA are registered from the position the block is about to enter, so
  // the pins line up exactly with the state and never glitch.
  function automatic logic [1:0] busLevels(
    input logic [3:0] st,
    input logic [1:0] q,
    input logic [2:0] bitIdx,
    input logic [7:0] aByte,
    input logic [7:0] wByte
  );
    logic [1:0] levels;
    levels = 2'b11;
    case (st)
      IDLE:      levels = 2'b11;
      START:     levels = {1'b1, ~q[1]};
      ADDR:      levels = {q[1], aByte[bitIdx]};
      WDATA:     levels = {q[1], wByte[bitIdx]};
      ADDR_ACK,
      WDATA_ACK,
      RDATA,
      RNACK:     levels = {q[1], 1'b1};
      STOP:      levels = {q[1], (q == 2'd3)};
      default:   levels = 2'b11;
    endcase
    return levels;
  endfunction

  assign accept     = (state == IDLE) && Start;
  assign quarterEnd = (quarterCnt == QUARTER_LAST);
  assign slotEnd    = quarterEnd && (quarter == 2'd3);
  assign sampleNow  = (state != IDLE) && quarterEnd && (quarter == 2'd2);

  // Next position in the transaction. The quarter counter runs in every
  // non-idle state, and the state/bit counter only move on the last clock of
  // a slot, which is what keeps SDA changes confined to q0 entry. The ACK
  // decision reads AckErr, which was already updated at the end of q2.
  always_comb begin
    nextState      = state;
    nextQuarterCnt = quarterCnt;
    nextQuarter    = quarter;
    nextBitCnt     = bitCnt;
    if (state == IDLE) begin
      nextQuarterCnt = 8'd0;
      nextQuarter    = 2'd0;
      if (Start) begin
        nextState = START;
      end
    end else begin
      nextQuarterCnt = quarterEnd ? 8'd0 : quarterCnt + 8'd1;
      if (quarterEnd) begin
        nextQuarter = quarter + 2'd1;
      end
      if (slotEnd) begin
        case (state)
          START: begin
            nextState  = ADDR;
            nextBitCnt = 3'd7;
          end
          ADDR: begin
            if (bitCnt == 3'd0) nextState = ADDR_ACK;
            else                nextBitCnt = bitCnt - 3'd1;
          end
          ADDR_ACK: begin
            if (AckErr) begin
              nextState = STOP;
            end else begin
              nextState  = addrByte[0] ? RDATA : WDATA;
              nextBitCnt = 3'd7;
            end
          end
          WDATA: begin
            if (bitCnt == 3'd0) nextState = WDATA_ACK;
            else                nextBitCnt = bitCnt - 3'd1;
          end
          WDATA_ACK: nextState = STOP;
          RDATA: begin
            if (bitCnt == 3'd0) nextState = RNACK;
            else                nextBitCnt = bitCnt - 3'd1;
          end
          RNACK:     nextState = STOP;
          STOP:      nextState = IDLE;
          default:   nextState = IDLE;
        endcase
      end
    end
  end

  assign busNext = busLevels(nextState, nextQuarter, nextBitCnt, addrByte, wrByte);

  // Sequential state. Reset drops straight back to an idle bus with no STOP
  // and no Done. Acceptance latches the request so later input changes are
  // harmless, and clears the previous result. The slave's SDA is sampled on
  // the last clock of q2, well after it had the whole SCL-low time to settle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      quarterCnt <= 8'd0;
      quarter    <= 2'd0;
      bitCnt     <= 3'd0;
      addrByte   <= 8'h00;
      wrByte     <= 8'h00;
      SCL        <= 1'b1;
      oSDA       <= 1'b1;
      RdData     <= 8'h00;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      AckErr     <= 1'b0;
    end else begin
      state      <= nextState;
      quarterCnt <= nextQuarterCnt;
      quarter    <= nextQuarter;
      bitCnt     <= nextBitCnt;
      SCL        <= busNext[1];
      oSDA       <= busNext[0];
      Done       <= (state == STOP) && slotEnd;
      if (accept) begin
        addrByte <= {Addr, RW};
        wrByte   <= WrData;
        AckErr   <= 1'b0;
        RdData   <= 8'h00;
        Busy     <= 1'b1;
      end else if ((state == STOP) && slotEnd) begin
        Busy <= 1'b0;
      end
      if (sampleNow) begin
        case (state)
          ADDR_ACK,
          WDATA_ACK: if (iSDA) AckErr <= 1'b1;
          RDATA:     RdData <= {RdData[6:0], iSDA};
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_master
//   Self-checking bench for i2c_master with CLK_DIV=4. A behavioural slave
//   logs SDA on every SCL rising edge, answers ACK/NACK and read data, and
//   watches the bus for START/STOP conditions and illegal SDA movement.
//   A table of directed transactions is run first, followed by hand-written
//   sequences for abort-by-reset and Start held through Done.
// ---------------------------------------------------------------------------
module tb_i2c_master;

  localparam int CLK_DIV   = 4;
  localparam int FULL_LAT  = 80 * CLK_DIV + 1;
  localparam int NACK_LAT  = 44 * CLK_DIV + 1;
  localparam int MAX_WAIT  = 2000;

  logic       CLK    = 1'b0;
  logic       Reset  = 1'b1;
  logic       Start  = 1'b0;
  logic       RW     = 1'b0;
  logic [6:0] Addr   = 7'h00;
  logic [7:0] WrData = 8'h00;
  logic       iSDA   = 1'b1;
  logic       SCL;
  logic       oSDA;
  logic [7:0] RdData;
  logic       Busy;
  logic       Done;
  logic       AckErr;

  int checks   = 0;
  int failures = 0;

  // slave configuration, set by the stimulus before each transaction
  logic       slvAckAddr = 1'b1;
  logic       slvAckData = 1'b1;
  logic [7:0] slvByte    = 8'h00;

  // slave and bus-monitor state
  logic        prevScl    = 1'b1;
  logic        prevSda    = 1'b1;
  logic        slvRead    = 1'b0;
  int          riseCount  = 0;
  logic [31:0] sdaLog     = '0;
  int          startConds = 0;
  int          stopConds  = 0;
  int          protoViol  = 0;
  int          doneCount  = 0;

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wrData;
    logic        ackAddr;
    logic        ackData;
    logic [7:0]  slvByte;
    int          collideAt;
    logic [7:0]  expRd;
    logic        expAckErr;
    int          expCycles;
    int          expRises;
    logic [31:0] expLog;
  } txnVec;

  txnVec vecs[8];

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .Start  (Start),
    .RW     (RW),
    .Addr   (Addr),
    .WrData (WrData),
    .SCL    (SCL),
    .oSDA   (oSDA),
    .iSDA   (iSDA),
    .RdData (RdData),
    .Busy   (Busy),
    .Done   (Done),
    .AckErr (AckErr)
  );

  always #5 CLK = ~CLK;

  // SDA seen on the 19 SCL rises of a full transaction: address byte, the
  // released ACK slot, data byte, the ACK/NACK slot, then the STOP rise (SDA=0)
  function automatic logic [31:0] fullLog(input logic [7:0] a, input logic [7:0] d);
    return {13'b0, a, 1'b1, d, 2'b10};
  endfunction

  // an address NACK only shows the address byte, the ACK slot and the STOP rise
  function automatic logic [31:0] nackLog(input logic [7:0] a);
    return {22'b0, a, 2'b10};
  endfunction

  // what the slave puts on SDA for a given bit slot (1-based SCL rise number)
  function automatic logic slaveBit(input int slot);
    if (slot == 9) return !slvAckAddr;
    if (slvRead && slot >= 10 && slot <= 17) return slvByte[17 - slot];
    if (!slvRead && slot == 18) return !slvAckData;
    return 1'b1;
  endfunction

  // Behavioural slave and protocol monitor, sampled on the falling CLK edge
  // so the DUT's registered outputs are stable. SDA may only move while SCL
  // is low; moves with SCL high are counted as START or STOP conditions and
  // the totals are checked at the end.
  always @(negedge CLK) begin
    if (!Reset) begin
      prevScl   <= 1'b1;
      prevSda   <= 1'b1;
      riseCount <= 0;
      sdaLog    <= '0;
      slvRead   <= 1'b0;
      iSDA      <= 1'b1;
    end else begin
      prevScl <= SCL;
      prevSda <= oSDA;
      if (SCL && prevScl && prevSda && !oSDA) begin
        startConds <= startConds + 1;
        riseCount  <= 0;
        sdaLog     <= '0;
        slvRead    <= 1'b0;
        iSDA       <= 1'b1;
      end else if (SCL && prevScl && !prevSda && oSDA) begin
        stopConds <= stopConds + 1;
      end else if (SCL && !prevScl) begin
        if (oSDA != prevSda) begin
          protoViol <= protoViol + 1;
          $display("[TB] protocol: SDA moved together with SCL rising at %0t", $time);
        end
        riseCount <= riseCount + 1;
        sdaLog    <= {sdaLog[30:0], oSDA};
        if (riseCount == 7) slvRead <= oSDA;
      end else if (!SCL && prevScl) begin
        iSDA <= slaveBit(riseCount + 1);
      end
    end
    if (Done) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one transaction from a falling edge and checks it end to end. The
  // request inputs are scrambled right after acceptance, and an optional
  // second Start with another address is pulsed while the block is busy.
  task automatic applyStimulus(input txnVec v, input string tag);
    int cycles;
    int doneBefore;
    slvAckAddr = v.ackAddr;
    slvAckData = v.ackData;
    slvByte    = v.slvByte;
    doneBefore = doneCount;
    RW     = v.rw;
    Addr   = v.addr;
    WrData = v.wrData;
    Start  = 1'b1;
    @(posedge CLK);
    cycles = 1;
    @(negedge CLK);
    Start  = 1'b0;
    RW     = ~v.rw;
    Addr   = ~v.addr;
    WrData = ~v.wrData;
    checkOutput($sformatf("%s.busyAfterAccept", tag), 32'(Busy), 32'd1);
    checkOutput($sformatf("%s.ackErrCleared", tag), 32'(AckErr), 32'd0);
    checkOutput($sformatf("%s.rdDataCleared", tag), 32'(RdData), 32'd0);
    while (!Done && cycles < MAX_WAIT) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      if (v.collideAt != 0 && cycles == v.collideAt) begin
        Start = 1'b1;
        RW    = 1'b1;
        Addr  = 7'h11;
      end else begin
        Start = 1'b0;
      end
    end
    checkOutput($sformatf("%s.doneSeen", tag), 32'(Done), 32'd1);
    checkOutput($sformatf("%s.latency", tag), 32'(cycles), 32'(v.expCycles));
    checkOutput($sformatf("%s.busyAtDone", tag), 32'(Busy), 32'd0);
    checkOutput($sformatf("%s.rdData", tag), 32'(RdData), 32'(v.expRd));
    checkOutput($sformatf("%s.ackErr", tag), 32'(AckErr), 32'(v.expAckErr));
    checkOutput($sformatf("%s.sdaBits", tag), sdaLog, v.expLog);
    checkOutput($sformatf("%s.sclRises", tag), 32'(riseCount), 32'(v.expRises));
    @(negedge CLK);
    checkOutput($sformatf("%s.donePulseWidth", tag), 32'(Done), 32'd0);
    checkOutput($sformatf("%s.doneCount", tag), 32'(doneCount - doneBefore), 32'd1);
    repeat (4) @(negedge CLK);
    checkOutput($sformatf("%s.noQueuedTxn", tag), 32'(Busy), 32'd0);
    checkOutput($sformatf("%s.rdDataHeld", tag), 32'(RdData), 32'(v.expRd));
  endtask

  initial begin
    int cycles;
    int doneBefore;
    txnVec postReset;

    //            rw    addr   wrData ackA  ackD  slvByte coll expRd  aErr lat       rises log
    vecs[0] = '{1'b0, 7'h2A, 8'hA5, 1'b1, 1'b1, 8'h00, 0,  8'h00, 1'b0, FULL_LAT, 19, fullLog(8'h54, 8'hA5)};
    vecs[1] = '{1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, 8'h3C, 0,  8'h3C, 1'b0, FULL_LAT, 19, fullLog(8'h55, 8'hFF)};
    vecs[2] = '{1'b0, 7'h2A, 8'h5A, 1'b0, 1'b1, 8'h00, 0,  8'h00, 1'b1, NACK_LAT, 10, nackLog(8'h54)};
    vecs[3] = '{1'b0, 7'h50, 8'h0F, 1'b1, 1'b0, 8'h00, 0,  8'h00, 1'b1, FULL_LAT, 19, fullLog(8'hA0, 8'h0F)};
    vecs[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 8'h81, 0,  8'h81, 1'b0, FULL_LAT, 19, fullLog(8'hFF, 8'hFF)};
    vecs[5] = '{1'b0, 7'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 0,  8'h00, 1'b0, FULL_LAT, 19, fullLog(8'h00, 8'hFF)};
    vecs[6] = '{1'b1, 7'h13, 8'h00, 1'b0, 1'b1, 8'hAA, 0,  8'h00, 1'b1, NACK_LAT, 10, nackLog(8'h27)};
    vecs[7] = '{1'b0, 7'h2A, 8'hC3, 1'b1, 1'b1, 8'h00, 20, 8'h00, 1'b0, FULL_LAT, 19, fullLog(8'h54, 8'hC3)};
    postReset = '{1'b0, 7'h2A, 8'h66, 1'b1, 1'b1, 8'h00, 0, 8'h00, 1'b0, FULL_LAT, 19, fullLog(8'h54, 8'h66)};

    // reset state with the clock running
    #2 Reset = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset.scl", 32'(SCL), 32'd1);
    checkOutput("reset.sda", 32'(oSDA), 32'd1);
    checkOutput("reset.busy", 32'(Busy), 32'd0);
    checkOutput("reset.done", 32'(Done), 32'd0);
    checkOutput("reset.ackErr", 32'(AckErr), 32'd0);
    checkOutput("reset.rdData", 32'(RdData), 32'd0);

    // the first table entry is requested in the same cycle reset releases
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // abort a write inside WDATA: slot 11, q0, SCL low and SDA = bit 6 of 0x99
    slvAckAddr = 1'b1;
    slvAckData = 1'b1;
    doneBefore = doneCount;
    RW     = 1'b0;
    Addr   = 7'h2A;
    WrData = 8'h99;
    Start  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (178) @(negedge CLK);
    checkOutput("abort.sclLowBefore", 32'(SCL), 32'd0);
    checkOutput("abort.sdaBit6Before", 32'(oSDA), 32'd0);
    #1 Reset = 1'b0;
    #1;
    checkOutput("abort.sclAsync", 32'(SCL), 32'd1);
    checkOutput("abort.sdaAsync", 32'(oSDA), 32'd1);
    checkOutput("abort.busyAsync", 32'(Busy), 32'd0);
    repeat (3) @(negedge CLK);
    checkOutput("abort.noDone", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("abort.rdData", 32'(RdData), 32'd0);
    Reset = 1'b1;
    applyStimulus(postReset, "postReset");

    // Start held high through Done restarts on the following cycle
    slvAckAddr = 1'b1;
    slvAckData = 1'b1;
    RW     = 1'b0;
    Addr   = 7'h2A;
    WrData = 8'h11;
    Start  = 1'b1;
    @(posedge CLK);
    cycles = 1;
    @(negedge CLK);
    while (!Done && cycles < MAX_WAIT) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
    end
    checkOutput("held.firstLatency", 32'(cycles), 32'(FULL_LAT));
    checkOutput("held.busyAtDone", 32'(Busy), 32'd0);
    @(posedge CLK);
    cycles = 1;
    @(negedge CLK);
    Start = 1'b0;
    checkOutput("held.restartBusy", 32'(Busy), 32'd1);
    checkOutput("held.restartNoDone", 32'(Done), 32'd0);
    while (!Done && cycles < MAX_WAIT) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
    end
    checkOutput("held.secondLatency", 32'(cycles), 32'(FULL_LAT));
    checkOutput("held.secondAckErr", 32'(AckErr), 32'd0);
    checkOutput("held.secondBits", sdaLog, fullLog(8'h54, 8'h11));

    // bus-level totals: 12 STARTs, 11 STOPs (the aborted write never stops)
    repeat (5) @(negedge CLK);
    checkOutput("protocol.sdaWhileSclHigh", 32'(protoViol), 32'd0);
    checkOutput("protocol.startConditions", 32'(startConds), 32'd12);
    checkOutput("protocol.stopConditions", 32'(stopConds), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
